// File: rtl/delay_probe_meter_if.sv
// Handshake and probe/echo bus between delay_probe_meter and the user plus the path under test.
// master = the meter itself, slave = the controlling / stimulating side.
interface delay_probe_meter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] echo_in;
  logic [WIDTH-1:0] probe_out;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] latency;

  modport master (
    input  start, abort, echo_in,
    output probe_out, busy, done, timeout, latency
  );

  modport slave (
    output start, abort, echo_in,
    input  probe_out, busy, done, timeout, latency
  );
endinterface

// File: rtl/delay_probe_meter.sv
// Measures the register latency of an external delay path by launching one MARKER word and timing its echo.
// Optional pre-probe flush of stale path contents is compiled in with `define DELAY_PROBE_FLUSH_EN.
module delay_probe_meter #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 8,
  parameter int               MAX_WAIT  = 255,
  parameter logic [WIDTH-1:0] MARKER    = 8'hA5,
  parameter int               FLUSH_LEN = 100
) (
  input logic                 clock,
  input logic                 rst_n,
  delay_probe_meter_if.master bus
);

  if (MAX_WAIT < 0 || MAX_WAIT > (1 << CNT_W) - 1 || MARKER == '0 ||
      FLUSH_LEN < 1 || FLUSH_LEN > (1 << CNT_W)) begin : g_bad_params
    $error("delay_probe_meter: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT);
`ifdef DELAY_PROBE_FLUSH_EN
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] probe_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             timeout_reg;
  logic [CNT_W-1:0] latency_reg;

  assign bus.probe_out = probe_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.timeout   = timeout_reg;
  assign bus.latency   = latency_reg;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      probe_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      latency_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (bus.abort) begin
        // Cancel silently: the previous result and timeout flag stay visible.
        state_reg <= S_IDLE;
        cnt_reg   <= '0;
        probe_reg <= '0;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            probe_reg <= '0;
            if (bus.start) begin
              cnt_reg     <= '0;
              timeout_reg <= 1'b0;
              busy_reg    <= 1'b1;
`ifdef DELAY_PROBE_FLUSH_EN
              state_reg   <= S_FLUSH;
`else
              probe_reg   <= MARKER;
              state_reg   <= S_WAIT;
`endif
            end
          end
`ifdef DELAY_PROBE_FLUSH_EN
          S_FLUSH: begin
            probe_reg <= '0;
            if (cnt_reg == FLUSH_LAST) begin
              probe_reg <= MARKER;
              cnt_reg   <= '0;
              state_reg <= S_WAIT;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
`endif
          S_WAIT: begin
            // Marker is on the wire for a single cycle; a match wins over timeout.
            probe_reg <= '0;
            if (bus.echo_in == MARKER) begin
              latency_reg <= cnt_reg;
              done_reg    <= 1'b1;
              busy_reg    <= 1'b0;
              state_reg   <= S_IDLE;
            end else if (cnt_reg == WAIT_LAST) begin
              latency_reg <= WAIT_LAST;
              timeout_reg <= 1'b1;
              done_reg    <= 1'b1;
              busy_reg    <= 1'b0;
              state_reg   <= S_IDLE;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          default: begin
            state_reg <= S_IDLE;
            probe_reg <= '0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delay_probe_meter.sv
// Randomized scoreboard bench for delay_probe_meter: a register-chain model of the path under test,
// expected results pushed at start time and checked by an independent done monitor.
module tb_delay_probe_meter;
  localparam int         WIDTH    = 8;
  localparam int         CNT_W    = 8;
  localparam int         MAX_WAIT = 255;
  localparam logic [7:0] MARKER   = 8'hA5;
`ifdef DELAY_PROBE_FLUSH_EN
  localparam int FLUSH_CYC = 100;
`else
  localparam int FLUSH_CYC = 0;
`endif

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  delay_probe_meter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  delay_probe_meter #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT), .MARKER(MARKER), .FLUSH_LEN(100)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Path under test: a 256-deep register chain tapped at path_len, or a stuck-at-zero path.
  logic [7:0] chain [0:255];
  int  path_len  = 0;
  bit  path_zero = 1'b1;
  bit  fill      = 1'b0;
  int  stale_idx = -1;

  always @(posedge clock) begin
    if (fill) begin
      for (int i = 0; i < 256; i++)
        chain[i] <= (i == stale_idx) ? MARKER : (8'($urandom) & 8'h7F);
    end else begin
      chain[0] <= bus.probe_out;
      for (int i = 1; i < 256; i++) chain[i] <= chain[i-1];
    end
  end

  always_comb begin
    if (path_zero)          bus.echo_in = '0;
    else if (path_len == 0) bus.echo_in = bus.probe_out;
    else                    bus.echo_in = chain[path_len-1];
  end

  typedef struct {
    int lat;
    bit to;
    int dcyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mk_cnt   = 0;
  int   last_lat = 0;
  bit   last_to  = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: N registers echo after N+1 edges past launch; no echo times out after MAX_WAIT+1.
  function automatic exp_t model(input bit zero, input int n, input int e0);
    exp_t r;
    if (zero || n > MAX_WAIT) begin
      r.lat  = MAX_WAIT;
      r.to   = 1'b1;
      r.dcyc = e0 + FLUSH_CYC + MAX_WAIT + 1;
    end else begin
      r.lat  = n;
      r.to   = 1'b0;
      r.dcyc = e0 + FLUSH_CYC + n + 1;
    end
    return r;
  endfunction

  always @(negedge clock) begin
    if (!rst_n) begin
      mk_cnt = 0;
    end else begin
      if (bus.probe_out == MARKER) mk_cnt++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          $display("txn done: latency=%0d timeout=%0d cycle=%0d (want %0d/%0d/%0d)",
                   bus.latency, bus.timeout, cyc, mon_e.lat, mon_e.to, mon_e.dcyc);
          check("latency", bus.latency, mon_e.lat);
          check("timeout", bus.timeout, mon_e.to);
          check("done_cycle", cyc, mon_e.dcyc);
          check("busy_at_done", bus.busy, 0);
          check("marker_cycles", mk_cnt, 1);
        end
        mk_cnt = 0;
      end else if (!bus.busy) begin
        mk_cnt = 0;
      end
    end
  end

  task automatic run_meas(input bit zero, input int n, input int stale, input bit push);
    int e0;
    path_zero = zero;
    path_len  = n;
    stale_idx = stale;
    fill      = 1'b1;
    @(negedge clock);
    fill      = 1'b0;
    bus.start = 1'b1;
    e0        = cyc + 1;
    if (push) begin
      exp_q.push_back(model(zero, n, e0));
      last_lat = model(zero, n, e0).lat;
      last_to  = model(zero, n, e0).to;
    end
    @(negedge clock);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("timeout_cleared", bus.timeout, 0);
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      @(negedge clock);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("done_wait_expired", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_probe"},   bus.probe_out, 0);
    check({tag, "_busy"},    bus.busy, 0);
    check({tag, "_done"},    bus.done, 0);
    check({tag, "_timeout"}, bus.timeout, 0);
    check({tag, "_latency"}, bus.latency, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got cycle %0d, expected completion", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clock);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clock);

    run_meas(1'b0, 30, -1, 1'b1); wait_done();
    run_meas(1'b0, 0, -1, 1'b1);  wait_done();
    run_meas(1'b1, 0, -1, 1'b1);  wait_done();
    run_meas(1'b0, 30, -1, 1'b1); wait_done();

    // Abort mid-measurement: no done, previous result retained.
    run_meas(1'b0, 90, -1, 1'b0);
    repeat (39) @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_latency", bus.latency, last_lat);
    check("abort_timeout", bus.timeout, last_to);
    repeat (120) @(negedge clock);
    run_meas(1'b0, 90, -1, 1'b1); wait_done();

    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_start_busy", bus.busy, 0);
    check("abort_start_probe", bus.probe_out, 0);
    repeat (3) @(negedge clock);
    check("abort_start_idle", bus.busy, 0);

    // Asynchronous reset in the middle of a measurement.
    run_meas(1'b0, 45, -1, 1'b0);
    repeat (19) @(negedge clock);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    run_meas(1'b0, 45, -1, 1'b1); wait_done();

`ifdef DELAY_PROBE_FLUSH_EN
    run_meas(1'b0, 60, 10, 1'b1); wait_done();
`endif

    run_meas(1'b0, 255, -1, 1'b1); wait_done();
    run_meas(1'b0, 1, -1, 1'b1);   wait_done();

    for (int t = 0; t < 8; t++) begin
      run_meas(($urandom_range(0, 4) == 0), int'($urandom_range(0, 255)), -1, 1'b1);
      wait_done();
    end

    repeat (5) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_probe_meter.md
Name: delay_probe_meter

Overview:
- Measures the latency, in clock cycles, of an external 8-bit registered delay path, such as the selectable delay lines.
- Drives a single marker word into the path input, watches the path output for the echo, and reports the stage count.
- Sits beside the delay-line mux in the top level for self-test and calibration of the selected tap.

Parameters:
- WIDTH, 8: data width of probe and echo buses.
- CNT_W, 8: width of the latency counter and result.
- MAX_WAIT, 255: largest measurable latency; must be ≤ 2^CNT_W−1.
- MARKER, 8'hA5: probe word; must be nonzero.
- FLUSH_LEN, 100: zero-drive cycles before the probe when the flush feature is compiled in.

Ports:
- clock, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request a measurement; sampled only in IDLE.
- abort, input, 1: cancel any measurement in progress.
- echo_in, input, WIDTH: output of the path under test.
- probe_out, output, WIDTH: drives the input of the path under test.
- busy, output, 1: high in any state except IDLE.
- done, output, 1: one-cycle pulse when a measurement ends (match or timeout).
- timeout, output, 1: sticky; last measurement found no echo.
- latency, output, CNT_W: last measured stage count; held until next completion.

Interface (decided): reset rst_n, asynchronous, active-low; clock clock.

Behaviour:
- Reset values: state IDLE; probe_out=0, busy=0, done=0, timeout=0, latency=0, cnt=0.
- All outputs are registered.
- States: IDLE, FLUSH (only with the macro), WAIT.
- IDLE:
  - probe_out=0.
  - On start=1 and abort=0 (edge e0): probe_out<=MARKER, cnt<=0, timeout<=0, go to WAIT.
  - start while busy is ignored.
- WAIT:
  - probe_out<=0 on every edge, so MARKER is driven for exactly one cycle.
  - At each edge, if echo_in==MARKER: latency<=cnt, done<=1, go to IDLE.
  - Else if cnt==MAX_WAIT: latency<=MAX_WAIT, timeout<=1, done<=1, go to IDLE.
  - Else cnt<=cnt+1.
- Latency definition:
  - A path of N registers driven by probe_out reports latency=N; detection occurs at edge e(N+1).
  - A combinational pass-through reports 0.
- Timeout: with no echo, done pulses at edge e(MAX_WAIT+1).
- Priority: match beats timeout on the same edge; echo values other than MARKER are ignored.
- abort=1 in any state:
  - Next edge: go to IDLE, probe_out<=0, cnt<=0.
  - No done pulse; latency and timeout keep their previous values.
  - abort beats start.
- Asynchronous reset mid-measurement returns immediately to reset values.
- done is high for exactly one cycle, coincident with busy falling. A new start is accepted on the edge after done.

Optional Feature:
- Macro DELAY_PROBE_FLUSH_EN.
- Defined:
  - start in IDLE enters FLUSH: probe_out=0 and cnt counts 0..FLUSH_LEN−1.
  - After FLUSH_LEN cycles, drive MARKER and enter WAIT as above (e0 is the flush-exit edge).
  - echo_in is ignored during FLUSH, which clears stale marker words left in the path.
  - abort and reset behave as in WAIT.
- Not defined: the FLUSH state and FLUSH_LEN logic are absent; start goes straight to WAIT.

Test Plan:
- 30-stage register chain between probe_out and echo_in; pulse start → done after 31 cycles, latency=30, timeout=0, probe_out==8'hA5 for exactly one cycle.
- echo_in wired directly to probe_out; start → done at first WAIT edge, latency=0.
- echo_in tied to 0, MAX_WAIT=255; start → done at e256, timeout=1, latency=255; second start clears timeout.
- 90-stage chain, abort at cycle 40 → busy falls next edge, no done, latency keeps prior value; start again → latency=90. Also abort+start together in IDLE → stays IDLE.
- rst_n low at cycle 20 of a 45-stage measurement → outputs zero immediately; after release, start → latency=45.
- With DELAY_PROBE_FLUSH_EN, FLUSH_LEN=100: preload the 60-stage chain with 8'hA5 at stage 10, then start → stale word ignored, latency=60, done at 100+61 cycles after start.
